// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch block.
// Contents: fault-code constants, the NOP encoding, the FSM state type and
// an even-parity helper used when IMEM_PARITY_EN is defined.
package imem_pkg;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_PARITY   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bit that makes the total number of ones in {bit, word} even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x WIDTH words, one synchronous write port and one
// synchronous read port. No reset; contents are set by the owner's clear sequence.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port, written at the clock edge
//   re_i/raddr_i     read enable and word index
//   rdata_o          read data, updated only when re_i was high (holds otherwise)
module imem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a valid/ready fetch interface.
// After reset an INIT sequence fills every word with NOP (one word per cycle,
// DEPTH cycles), then RUN accepts program loads and fetches.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per word
// and report parity mismatches as fault 11.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_pc      fetch request (byte address)
//   rsp_valid/rsp_ready             fetch response handshake
//   rsp_instr/rsp_pc/rsp_fault      response payload (fault: 00 ok, 01 misaligned,
//                                   10 out of range, 11 parity)
//   load_valid/load_ready/load_addr/load_data  program-load write port
//   init_done                       high once the clear sequence has finished
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_fault,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned WORD_W = 33;
`else
  localparam int unsigned WORD_W = 32;
`endif
  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;

  logic               arr_we;
  logic [IDX_W-1:0]   arr_waddr;
  logic [31:0]        wr_word;
  logic [WORD_W-1:0]  arr_wdata;
  logic [WORD_W-1:0]  rd_word;

  logic               req_fire;
  logic [1:0]         req_fault;

  logic               rsp_valid_q;
  logic [ADDR_W-1:0]  rsp_pc_q;
  logic [1:0]         req_fault_q;
  logic               rd_live_q;   // rd_word holds data from a real fetch
  logic               parity_err;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // FSM next state: leave INIT after the last word has been cleared
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs: write-port mux and handshake readiness
  always_comb begin
    init_done  = 1'b0;
    load_ready = 1'b0;
    req_ready  = 1'b0;
    arr_we     = 1'b0;
    arr_waddr  = init_cnt_q;
    wr_word    = NOP_INSTR;
    unique case (state_q)
      ST_INIT: arr_we = 1'b1;
      ST_RUN: begin
        init_done  = 1'b1;
        load_ready = 1'b1;
        // Loads win; a fetch also waits while a response is stalled.
        req_ready  = !load_valid && (!rsp_valid_q || rsp_ready);
        arr_we     = load_valid;
        arr_waddr  = load_addr[IDX_W+1:2];
        wr_word    = load_data;
      end
      default: ;
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign arr_wdata = {even_parity(wr_word), wr_word};
`else
  assign arr_wdata = wr_word;
`endif

  assign req_fire = req_valid && req_ready;

  always_comb begin
    req_fault = FAULT_OK;
    if (req_pc[1:0] != 2'b00)                req_fault = FAULT_MISALIGN;
    else if (req_pc[ADDR_W-1:2] >= DEPTH_WORDS) req_fault = FAULT_RANGE;
  end

  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (req_fire),
    .raddr_i (req_pc[IDX_W+1:2]),
    .rdata_o (rd_word)
  );

  // Response register: only updated on an accepted fetch, so the payload is
  // automatically stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      req_fault_q <= FAULT_OK;
      rd_live_q   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_pc_q    <= req_pc;
      req_fault_q <= req_fault;
      rd_live_q   <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  assign parity_err = rd_live_q && (^rd_word);
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    rsp_fault = req_fault_q;
    if (req_fault_q == FAULT_OK && parity_err) rsp_fault = FAULT_PARITY;
    rsp_instr = (rd_live_q && rsp_fault == FAULT_OK) ? rd_word[31:0] : NOP_INSTR;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;

endmodule
